// File: rtl/csm_pkg.sv
// csm_pkg
// Shared definitions for the CSM shared-memory responder.
//   DEF_DATABITS / DEF_ERRBITS : default address/data and error-code widths
//   err_t        : response status returned on X_err
//   owner_t      : who currently holds the exclusive lock
//   port_state_t : per-port command sequencing state
//   cmd_t        : command decoded from hold/release/rw at accept
//   decode_cmd() : hold/release/rw -> cmd_t
package csm_pkg;

    localparam int DEF_DATABITS = 8;
    localparam int DEF_ERRBITS  = 2;

    typedef enum logic [1:0] {
        ERR_OK       = 2'd0,
        ERR_LOCKED   = 2'd1,
        ERR_NOTOWNER = 2'd2,
        ERR_CONFLICT = 2'd3
    } err_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } port_state_t;

    typedef enum logic [2:0] {
        CMD_READ  = 3'd0,
        CMD_WRITE = 3'd1,
        CMD_HOLD  = 3'd2,
        CMD_REL   = 3'd3,
        CMD_BAD   = 3'd4
    } cmd_t;

    // Lock requests outrank rw; asking for hold and release at once is
    // treated as a malformed command rather than picking one of them.
    function automatic cmd_t decode_cmd(input logic rw, input logic hold, input logic rel);
        cmd_t c;
        if (hold && rel) begin
            c = CMD_BAD;
        end else if (hold) begin
            c = CMD_HOLD;
        end else if (rel) begin
            c = CMD_REL;
        end else if (rw) begin
            c = CMD_WRITE;
        end else begin
            c = CMD_READ;
        end
        return c;
    endfunction

endpackage

// File: rtl/csm_port_fsm.sv
// csm_port_fsm
// One requester port of the CSM responder: decodes and latches a command,
// sequences IDLE -> BUSY -> RESP -> IDLE and owns the registered ack, err
// and out_data outputs of that port.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   in_ad             : address at accept, write data during BUSY
//   rw, enable        : 0 read / 1 write, command request
//   hold, rel         : lock / unlock requests
//   grant             : status decided by the top for the command being accepted
//   drop              : same-address write collision lost at the BUSY edge
//   rd_data           : memory contents at the latched address
//   accept, cmd       : accept strobe and the live decoded command
//   commit, addr,
//   wdata             : write-commit strobe, latched address, write data
//   ack, err, out_data: registered response outputs
module csm_port_fsm
    import csm_pkg::*;
#(
    parameter int DATABITS = DEF_DATABITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATABITS-1:0] in_ad,
    input  logic                rw,
    input  logic                enable,
    input  logic                hold,
    input  logic                rel,
    input  err_t                grant,
    input  logic                drop,
    input  logic [DATABITS-1:0] rd_data,
    output logic                accept,
    output cmd_t                cmd,
    output logic                commit,
    output logic [DATABITS-1:0] addr,
    output logic [DATABITS-1:0] wdata,
    output logic                ack,
    output err_t                err,
    output logic [DATABITS-1:0] out_data
);

    port_state_t                state;
    port_state_t                next_state;
    cmd_t                       cmd_q;
    err_t                       status_q;
    logic        [DATABITS-1:0] addr_q;

    assign cmd    = decode_cmd(rw, hold, rel);
    assign accept = (state == IDLE) && enable;
    assign addr   = addr_q;
    // Write data is whatever sits on in_ad during BUSY; the top samples it
    // at the BUSY edge together with commit.
    assign wdata  = in_ad;
    assign commit = (state == BUSY) && (cmd_q == CMD_WRITE) && (status_q == ERR_OK);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each non-idle state lasts exactly one cycle; enable only matters in IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = BUSY;
            BUSY:    next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command latch and response registers. The permission verdict is
    // captured at accept; the response is published at the BUSY edge so it
    // is visible throughout RESP and held until the next response.
    always_ff @(posedge clk) begin
        if (reset) begin
            ack      <= 1'b0;
            err      <= ERR_OK;
            out_data <= '0;
            cmd_q    <= CMD_READ;
            status_q <= ERR_OK;
            addr_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        ack      <= 1'b0;
                        cmd_q    <= cmd;
                        addr_q   <= in_ad;
                        status_q <= grant;
                    end else begin
                        ack <= 1'b1;
                    end
                end
                BUSY: begin
                    ack <= 1'b1;
                    err <= drop ? ERR_CONFLICT : status_q;
                    // Locked reads report zero rather than stale data.
                    if (cmd_q == CMD_READ) begin
                        out_data <= (status_q == ERR_OK) ? rd_data : '0;
                    end
                end
                default: begin
                    ack <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/csm_responder.sv
// csm_responder
// Responder end of the CSM shared-memory bus. Serves requesters A and B,
// each through its own csm_port_fsm, over a 2**DATABITS-entry memory with an
// exclusive hold/release lock.
// Ports (X = A or B):
//   clk, reset     : clock, synchronous active-high reset
//   X_in_AD        : address on the accept cycle, write data on the next
//   X_rw           : 0 read, 1 write
//   X_enable       : command request
//   X_hold         : lock request (takes precedence over rw)
//   X_release      : unlock request
//   X_ack          : port idle/ready or response valid
//   X_err          : response status (err_t encoding)
//   X_out_data     : read data
module csm_responder
    import csm_pkg::*;
#(
    parameter int DATABITS = DEF_DATABITS,
    parameter int ERRBITS  = DEF_ERRBITS
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [DATABITS-1:0] A_in_AD,
    input  logic                A_rw,
    input  logic                A_enable,
    input  logic                A_hold,
    input  logic                A_release,
    output logic                A_ack,
    output logic [ERRBITS-1:0]  A_err,
    output logic [DATABITS-1:0] A_out_data,
    input  logic [DATABITS-1:0] B_in_AD,
    input  logic                B_rw,
    input  logic                B_enable,
    input  logic                B_hold,
    input  logic                B_release,
    output logic                B_ack,
    output logic [ERRBITS-1:0]  B_err,
    output logic [DATABITS-1:0] B_out_data
);

    logic [DATABITS-1:0] mem [2**DATABITS];

    owner_t owner_q;
    owner_t owner_d;

    logic                a_accept, b_accept;
    cmd_t                a_cmd, b_cmd;
    logic                a_commit, b_commit;
    logic [DATABITS-1:0] a_addr, b_addr;
    logic [DATABITS-1:0] a_wdata, b_wdata;
    logic [DATABITS-1:0] a_rd, b_rd;
    err_t                a_grant, b_grant;
    err_t                a_err, b_err;
    logic                b_drop;
    logic                a_hold_ok, b_hold_ok;
    logic                a_blocked, b_blocked;

    csm_port_fsm #(.DATABITS(DATABITS)) u_port_a (
        .clk      (clk),
        .reset    (reset),
        .in_ad    (A_in_AD),
        .rw       (A_rw),
        .enable   (A_enable),
        .hold     (A_hold),
        .rel      (A_release),
        .grant    (a_grant),
        .drop     (1'b0),
        .rd_data  (a_rd),
        .accept   (a_accept),
        .cmd      (a_cmd),
        .commit   (a_commit),
        .addr     (a_addr),
        .wdata    (a_wdata),
        .ack      (A_ack),
        .err      (a_err),
        .out_data (A_out_data)
    );

    csm_port_fsm #(.DATABITS(DATABITS)) u_port_b (
        .clk      (clk),
        .reset    (reset),
        .in_ad    (B_in_AD),
        .rw       (B_rw),
        .enable   (B_enable),
        .hold     (B_hold),
        .rel      (B_release),
        .grant    (b_grant),
        .drop     (b_drop),
        .rd_data  (b_rd),
        .accept   (b_accept),
        .cmd      (b_cmd),
        .commit   (b_commit),
        .addr     (b_addr),
        .wdata    (b_wdata),
        .ack      (B_ack),
        .err      (b_err),
        .out_data (B_out_data)
    );

    assign A_err = ERRBITS'(a_err);
    assign B_err = ERRBITS'(b_err);

    // Reads see memory before any write committing on the same edge.
    assign a_rd = mem[a_addr];
    assign b_rd = mem[b_addr];

    // On a same-address double commit A's data wins and B is told so.
    assign b_drop = a_commit && b_commit && (a_addr == b_addr);

    // Permission and same-edge arbitration. Everything is judged against the
    // owner before the edge, except that a hold granted on this edge locks
    // out the other port's read/write/hold; A's hold outranks B's.
    always_comb begin
        a_grant   = ERR_OK;
        b_grant   = ERR_OK;
        owner_d   = owner_q;
        a_hold_ok = a_accept && (a_cmd == CMD_HOLD) && (owner_q != OWN_B);
        b_hold_ok = b_accept && (b_cmd == CMD_HOLD) && (owner_q != OWN_A) && !a_hold_ok;
        a_blocked = (owner_q == OWN_B) || b_hold_ok;
        b_blocked = (owner_q == OWN_A) || a_hold_ok;

        case (a_cmd)
            CMD_BAD: a_grant = ERR_CONFLICT;
            CMD_REL: a_grant = (owner_q == OWN_A) ? ERR_OK : ERR_NOTOWNER;
            default: a_grant = a_blocked ? ERR_LOCKED : ERR_OK;
        endcase

        case (b_cmd)
            CMD_BAD: b_grant = ERR_CONFLICT;
            CMD_REL: b_grant = (owner_q == OWN_B) ? ERR_OK : ERR_NOTOWNER;
            default: b_grant = b_blocked ? ERR_LOCKED : ERR_OK;
        endcase

        if (a_hold_ok) begin
            owner_d = OWN_A;
        end else if (b_hold_ok) begin
            owner_d = OWN_B;
        end else if (a_accept && (a_cmd == CMD_REL) && (owner_q == OWN_A)) begin
            owner_d = OWN_NONE;
        end else if (b_accept && (b_cmd == CMD_REL) && (owner_q == OWN_B)) begin
            owner_d = OWN_NONE;
        end
    end

    // Lock owner register.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Memory has no reset; reset only blocks a write that is mid-flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (a_commit) begin
                mem[a_addr] <= a_wdata;
            end
            if (b_commit && !b_drop) begin
                mem[b_addr] <= b_wdata;
            end
        end
    end

endmodule
